// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display driver.
// Segment vectors are {a,b,c,d,e,f,g}, active-low.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t HEX_PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    return HEX_PAT[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-nibble to active-low segment lookup with a blank override.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with load-captured shadow data.
// Optional leading-zero blanking is built when SEG7_LEADING_ZERO_BLANK_EN is defined.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 100000,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output seg_t                    seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dp;

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] onehot;
  seg_t                  dec_seg;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [NUM_DIGITS-1:0] blank_next;
  logic                  zero_above;

  // Mask is derived from the incoming value at load time so decode stays one register deep.
  always_comb begin
    blank_next = '0;
    zero_above = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above & (value[4*k +: 4] == 4'h0);
      blank_next[k] = zero_above & ~dp_in[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_mask <= '0;
    end else if (load) begin
      blank_mask <= blank_next;
    end
  end
`endif

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    onehot    = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib   = sh_val[4*k +: 4];
        cur_dp    = sh_dp[k];
        onehot[k] = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        cur_blank = blank_mask[k];
`endif
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble (cur_nib),
    .blank  (cur_blank),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_val <= '0;
      sh_dp  <= '0;
    end else if (load) begin
      sh_val <= value;
      sh_dp  <= dp_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (cnt == CW'(REFRESH_DIV - 1)) begin
        cnt <= '0;
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= AN_OFF;
    end else if (en) begin
      seg <= dec_seg;
      dp  <= cur_blank | ~cur_dp;
      an  <= AN_ACTIVE_LOW ? ~onehot : onehot;
    end else begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= AN_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed self-checking bench for seg7_mux_driver with NUM_DIGITS=4, REFRESH_DIV=4.
module tb_seg7_mux_driver;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0111000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg7_mux_driver #(
    .NUM_DIGITS    (4),
    .REFRESH_DIV   (4),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .value (value),
    .dp_in (dp_in),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse between edges, then capture v/d with scanning disabled.
  task automatic restart(input logic [15:0] v, input logic [3:0] d);
    rst  = 1'b1;
    en   = 1'b0;
    load = 1'b0;
    #3;
    rst   = 1'b0;
    value = v;
    dp_in = d;
    load  = 1'b1;
    tick();
    load = 1'b0;
    en   = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; load = 1'b0; value = '0; dp_in = '0;
    tick();
    n_checks++;
    if (seg !== SB) begin n_fail++; $display("FAIL reset_seg got %b want %b", seg, SB); end
    n_checks++;
    if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b want 1", dp); end
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an got %b want 1111", an); end
    rst = 1'b0;
    value = 16'h12AF; dp_in = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL load_en0_an got %b want 1111", an); end
  endtask

  task automatic test_scan;
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg = '{SF, SA, S2, S1};
    en = 1'b1;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        exp_an = 4'b1111;
        exp_an[d] = 1'b0;
        n_checks++;
        if (an !== exp_an) begin n_fail++; $display("FAIL scan_an d%0d c%0d got %b want %b", d, c, an, exp_an); end
        n_checks++;
        if (seg !== exp_seg[d]) begin n_fail++; $display("FAIL scan_seg d%0d c%0d got %b want %b", d, c, seg, exp_seg[d]); end
        n_checks++;
        if (dp !== 1'b1) begin n_fail++; $display("FAIL scan_dp d%0d c%0d got %b want 1", d, c, dp); end
      end
    end
  endtask

  task automatic test_async_reset;
    repeat (8) tick();
    tick();
    n_checks++;
    if (an !== 4'b1011) begin n_fail++; $display("FAIL pre_rst_an got %b want 1011", an); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (seg !== SB) begin n_fail++; $display("FAIL async_rst_seg got %b want %b", seg, SB); end
    n_checks++;
    if (an !== 4'b1111) begin n_fail++; $display("FAIL async_rst_an got %b want 1111", an); end
    n_checks++;
    if (dp !== 1'b1) begin n_fail++; $display("FAIL async_rst_dp got %b want 1", dp); end
    #1 rst = 1'b0;
    tick();
    n_checks++;
    if (an !== 4'b1110) begin n_fail++; $display("FAIL post_rst_an got %b want 1110", an); end
    n_checks++;
    if (seg !== S0) begin n_fail++; $display("FAIL post_rst_seg got %b want %b", seg, S0); end
  endtask

  task automatic test_en_pause;
    restart(16'h12AF, 4'b0000);
    repeat (4) tick();
    tick();
    tick();
    n_checks++;
    if (an !== 4'b1101) begin n_fail++; $display("FAIL pause_pre_an got %b want 1101", an); end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (an !== 4'b1111) begin n_fail++; $display("FAIL pause_an cyc%0d got %b want 1111", i, an); end
      n_checks++;
      if (seg !== SB) begin n_fail++; $display("FAIL pause_seg cyc%0d got %b want %b", i, seg, SB); end
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (an !== 4'b1101 || seg !== SA) begin n_fail++; $display("FAIL resume1 got an=%b seg=%b want an=1101 seg=%b", an, seg, SA); end
    tick();
    n_checks++;
    if (an !== 4'b1101 || seg !== SA) begin n_fail++; $display("FAIL resume2 got an=%b seg=%b want an=1101 seg=%b", an, seg, SA); end
    tick();
    n_checks++;
    if (an !== 4'b1011 || seg !== S2) begin n_fail++; $display("FAIL resume3 got an=%b seg=%b want an=1011 seg=%b", an, seg, S2); end
  endtask

  task automatic test_load_at_advance;
    int         order [4];
    logic [3:0] exp_an;
    logic [6:0] exp_s;
    logic       exp_dp;
    order = '{3, 0, 1, 2};
    tick();
    tick();
    n_checks++;
    if (an !== 4'b1011) begin n_fail++; $display("FAIL adv_pre_an got %b want 1011", an); end
    value = 16'h0000; dp_in = 4'b0100; load = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if (an !== 4'b1011 || seg !== S2 || dp !== 1'b1) begin
      n_fail++; $display("FAIL adv_edge got an=%b seg=%b dp=%b want an=1011 seg=%b dp=1", an, seg, dp, S2);
    end
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        exp_an = 4'b1111;
        exp_an[order[j]] = 1'b0;
        exp_dp = (order[j] == 2) ? 1'b0 : 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        exp_s = (order[j] == 3 || order[j] == 1) ? SB : S0;
`else
        exp_s = S0;
`endif
        n_checks++;
        if (an !== exp_an) begin n_fail++; $display("FAIL adv_an d%0d c%0d got %b want %b", order[j], c, an, exp_an); end
        n_checks++;
        if (seg !== exp_s) begin n_fail++; $display("FAIL adv_seg d%0d c%0d got %b want %b", order[j], c, seg, exp_s); end
        n_checks++;
        if (dp !== exp_dp) begin n_fail++; $display("FAIL adv_dp d%0d c%0d got %b want %b", order[j], c, dp, exp_dp); end
      end
    end
  endtask

  task automatic test_blank;
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    exp_seg = '{S0, S5, SB, SB};
`else
    exp_seg = '{S0, S5, S0, S0};
`endif
    restart(16'h0050, 4'b0000);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        exp_an = 4'b1111;
        exp_an[d] = 1'b0;
        n_checks++;
        if (an !== exp_an) begin n_fail++; $display("FAIL blank_an d%0d c%0d got %b want %b", d, c, an, exp_an); end
        n_checks++;
        if (seg !== exp_seg[d]) begin n_fail++; $display("FAIL blank_seg d%0d c%0d got %b want %b", d, c, seg, exp_seg[d]); end
        n_checks++;
        if (dp !== 1'b1) begin n_fail++; $display("FAIL blank_dp d%0d c%0d got %b want 1", d, c, dp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_async_reset();
    test_en_pause();
    test_load_at_advance();
    test_blank();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
